iotdf_round_ctrl: RTL and testbench
===================================

# iotdf_round_ctrl

Front-end sequencer for the IOTDF filter datapath. It takes the 8-bit byte stream, assembles MSB-first 128-bit words, and groups 8 words into a round. It tells the compute datapath where each round starts and ends, throttles the source with `busy` while the datapath finishes a round, and forwards kept results to `valid`/`iot_out`.

## Interface
- `WORDS_PER_ROUND`, default 8: words per round; must be a power of two, at least 2.
- `DP_TIMEOUT`, default 15: maximum cycles in WAIT_DP before the round is abandoned; at least 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_en` in 1: byte strobe; a byte is accepted only when `in_en=1` and `busy=0`.
- `iot_in` in 8: data byte.
- `fn_sel` in 3: function code, 1..7; 0 is treated as 1.
- `dp_done` in 1: one-cycle result strobe from the datapath.
- `dp_keep` in 1: qualifies `dp_done`; 1 means the result is published.
- `dp_result` in 128: datapath result, sampled when `dp_done=1`.
- `busy` out 1: source must stall.
- `word_vld` out 1: one-cycle pulse; `word` holds a complete word.
- `word` out 128: assembled word; first byte of the word sits in [127:120].
- `dp_first` out 1: qualifies `word_vld`; word index 0 of the round.
- `dp_last` out 1: qualifies `word_vld`; word index WORDS_PER_ROUND-1.
- `dp_fn` out 3: function code presented to the datapath.
- `valid` out 1: one-cycle output strobe.
- `iot_out` out 128: published result.
- `err` out 1: sticky; set when a round times out.

## Operation
- State machine states: COLLECT and WAIT_DP. Reset enters COLLECT.
- Byte counter `bc` is 4 bits; word counter `wc` is log2(WORDS_PER_ROUND) bits.
- Accepted byte: shift register ← {sr[119:0], iot_in}; `bc` increments.
- When the accepted byte has `bc`=15:
  - Next cycle, `word_vld`=1 and `word` = the completed word.
  - `dp_first` = (`wc`==0); `dp_last` = (`wc`==WORDS_PER_ROUND-1).
  - `bc` wraps to 0; `wc` increments and wraps from the last index to 0.
- COLLECT → WAIT_DP on the same edge that accepts the final byte of the round. `busy` rises on that edge.
- WAIT_DP:
  - Stays until `dp_done`, or until the wait counter reaches DP_TIMEOUT.
  - Either event returns to COLLECT and clears `busy` on that edge.
  - Timeout also sets `err`; any later `dp_done` from the abandoned round is still honoured as a normal result.
- `dp_done` is honoured in any state. This supports per-word pass-through for fn 4/5 during COLLECT.
  - If `dp_keep`=1: next cycle `valid`=1 and `iot_out`=`dp_result`.
  - If `dp_keep`=0: `valid` stays 0 and `iot_out` is unchanged.
- `iot_out` holds its last value when `valid`=0.
- Boundary rules:
  - `in_en` while `busy`=1: byte dropped; counters unchanged.
  - `dp_done` on the same cycle the timeout expires: `dp_done` wins and `err` is not set.
  - `rst` mid-round: partial word and round discarded; counters cleared.
- Reset values: `busy`=0, `word_vld`=0, `word`=0, `dp_first`=0, `dp_last`=0, `dp_fn`=1, `valid`=0, `iot_out`=0, `err`=0. `bc`, `wc` and the wait counter are all 0.

## Timing
- Input latency: final byte of a word accepted at edge k → `word_vld` high in the cycle after edge k.
- Output latency: `dp_done` sampled at edge k → `valid` high in the cycle after edge k.
- `busy` is registered and has no combinational path from any input.
- `busy` high-time per round is 1..DP_TIMEOUT cycles.
- Throughput: 1 byte/cycle in COLLECT. A round of 128 bytes costs at least 129 cycles.

## Configuration
- Macro `IOTDF_CTRL_FNLATCH_EN`:
  - Defined: `fn_sel` is sampled when byte 0 of word 0 of a round is accepted. `dp_fn` holds that value for the whole round, so a mid-round `fn_sel` change takes effect at the next round.
  - Undefined: `dp_fn` follows `fn_sel` combinationally, with 0 mapped to 1.

## Test plan
- Reset, then 128 bytes 0x00..0x7F with `in_en`=1 every cycle:
  - 8 `word_vld` pulses; first word = 0x000102…0F.
  - `dp_first` only on word 0; `dp_last` only on word 7.
  - `busy`=1 from the edge accepting byte 0x7F.
- In WAIT_DP, `dp_done`=1, `dp_keep`=1, `dp_result`=0xAFFF…FF two cycles after `busy` rises:
  - One `valid` pulse with `iot_out`=0xAFFF…FF.
  - `busy` falls on the `dp_done` edge.
- Present bytes 0x55 while `busy`=1: none are accepted; the next round's word 0 starts from the first byte presented after `busy` falls.
- No `dp_done` after a round: `busy` is held DP_TIMEOUT=15 cycles, then `err`=1 and state is COLLECT. In a separate run, `dp_done` on the expiry cycle leaves `err`=0.
- `dp_done` with `dp_keep`=0 mid-COLLECT: `valid` stays 0 and `iot_out` is unchanged. The same with `dp_keep`=1 gives `valid`=1.
- With `IOTDF_CTRL_FNLATCH_EN`:
  - Change `fn_sel` from 3 to 6 at byte 40: `dp_fn` stays 3 until the next round's byte 0.
  - Without the macro, `dp_fn`=6 in the cycle after the change.
  - With or without the macro, `fn_sel`=0 gives `dp_fn`=1.

Source files
------------

// File: rtl/iotdf_round_ctrl_if.sv
// Byte-stream / datapath bundle for the IOTDF round sequencer.
// slave: sequencer view (bytes + dp results in, words + results out).
interface iotdf_round_ctrl_if;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic         dp_done;
    logic         dp_keep;
    logic [127:0] dp_result;
    logic         busy;
    logic         word_vld;
    logic [127:0] word;
    logic         dp_first;
    logic         dp_last;
    logic [2:0]   dp_fn;
    logic         valid;
    logic [127:0] iot_out;
    logic         err;

    modport slave (
        input  in_en, iot_in, fn_sel,
        input  dp_done, dp_keep, dp_result,
        output busy, word_vld, word,
        output dp_first, dp_last, dp_fn,
        output valid, iot_out, err
    );

    modport master (
        output in_en, iot_in, fn_sel,
        output dp_done, dp_keep, dp_result,
        input  busy, word_vld, word,
        input  dp_first, dp_last, dp_fn,
        input  valid, iot_out, err
    );
endinterface

// File: rtl/iotdf_round_ctrl.sv
// IOTDF front-end: packs bytes MSB-first into 128-bit words, groups them
// into rounds, stalls the source while the datapath finishes a round.
// Ports: clk, rst (async, active-high), bus (iotdf_round_ctrl_if.slave).
// Option: IOTDF_CTRL_FNLATCH_EN latches fn_sel at the start of each round;
// otherwise dp_fn follows fn_sel combinationally (0 mapped to 1).
module iotdf_round_ctrl #(
    parameter int WORDS_PER_ROUND = 8,
    parameter int DP_TIMEOUT      = 15
) (
    input  logic             clk,
    input  logic             rst,
    iotdf_round_ctrl_if.slave bus
);
    localparam int WCW = $clog2(WORDS_PER_ROUND);
    localparam int TW  = $clog2(DP_TIMEOUT + 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(WORDS_PER_ROUND - 1);
    localparam logic [TW-1:0]  T_LAST = TW'(DP_TIMEOUT - 1);

    typedef enum logic {COLLECT, WAIT_DP} state_t;

    state_t         state, state_nx;
    logic [119:0]   sr;
    logic [3:0]     bc;
    logic [WCW-1:0] wc;
    logic [TW-1:0]  tcnt;
    logic           accept;
    logic           word_end;
    logic           round_end;
    logic           timeout;
    logic           set_err;
    logic [2:0]     fn_map;

    // busy is a pure decode of the state flop: registered, no input path.
    assign bus.busy  = (state == WAIT_DP);
    assign accept    = bus.in_en && (state == COLLECT);
    assign word_end  = accept && (bc == 4'd15);
    assign round_end = word_end && (wc == W_LAST);
    assign timeout   = (state == WAIT_DP) && (tcnt == T_LAST);
    assign fn_map    = (bus.fn_sel == 3'd0) ? 3'd1 : bus.fn_sel;

    always_comb begin
        state_nx = state;
        set_err  = 1'b0;
        unique case (state)
            COLLECT: begin
                if (round_end)
                    state_nx = WAIT_DP;
            end
            WAIT_DP: begin
                // a result arriving on the expiry cycle beats the timeout
                if (bus.dp_done) begin
                    state_nx = COLLECT;
                end else if (timeout) begin
                    state_nx = COLLECT;
                    set_err  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr           <= '0;
            bc           <= '0;
            wc           <= '0;
            tcnt         <= '0;
            bus.word_vld <= 1'b0;
            bus.word     <= '0;
            bus.dp_first <= 1'b0;
            bus.dp_last  <= 1'b0;
            bus.valid    <= 1'b0;
            bus.iot_out  <= '0;
            bus.err      <= 1'b0;
        end else begin
            bus.word_vld <= word_end;
            bus.dp_first <= word_end && (wc == '0);
            bus.dp_last  <= word_end && (wc == W_LAST);
            if (accept) begin
                sr <= {sr[111:0], bus.iot_in};
                bc <= bc + 4'd1;
            end
            if (word_end) begin
                bus.word <= {sr, bus.iot_in};
                wc       <= wc + 1'b1;
            end
            if (state == WAIT_DP && state_nx == WAIT_DP)
                tcnt <= tcnt + 1'b1;
            else
                tcnt <= '0;
            // results are honoured in either state
            bus.valid <= bus.dp_done && bus.dp_keep;
            if (bus.dp_done && bus.dp_keep)
                bus.iot_out <= bus.dp_result;
            if (set_err)
                bus.err <= 1'b1;
        end
    end

`ifdef IOTDF_CTRL_FNLATCH_EN
    logic [2:0] fn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fn_q <= 3'd1;
        else if (accept && bc == 4'd0 && wc == '0)
            fn_q <= fn_map;
    end

    assign bus.dp_fn = fn_q;
`else
    assign bus.dp_fn = fn_map;
`endif
endmodule

// File: tb/tb_iotdf_round_ctrl.sv
// Randomized self-checking bench for iotdf_round_ctrl.
// Reference: rounds of 128 accepted bytes, words sliced 16 bytes at a time.
module tb_iotdf_round_ctrl;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    iotdf_round_ctrl_if bus();

    iotdf_round_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int           pass  = 0;
    int           total = 0;
    logic [127:0] exp_out;
    bit           exp_err;
    logic [2:0]   lat_fn;
    logic [2:0]   cur_fn;

    function automatic logic [2:0] fmap(input logic [2:0] f);
        return (f == 3'd0) ? 3'd1 : f;
    endfunction

    function automatic logic [2:0] fn_exp();
`ifdef IOTDF_CTRL_FNLATCH_EN
        return lat_fn;
`else
        return fmap(cur_fn);
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_en = 0; bus.iot_in = 0; cur_fn = 0; bus.fn_sel = 0;
        bus.dp_done = 0; bus.dp_keep = 0; bus.dp_result = 0;
        exp_out = '0; exp_err = 0; lat_fn = 3'd1;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else pass++;
        total++; if (bus.word_vld !== 1'b0) $display("FAIL rst_word_vld got %b want 0", bus.word_vld); else pass++;
        total++; if (bus.word !== 128'd0) $display("FAIL rst_word got %h want 0", bus.word); else pass++;
        total++; if (bus.dp_first !== 1'b0 || bus.dp_last !== 1'b0) $display("FAIL rst_first_last got %b%b want 00", bus.dp_first, bus.dp_last); else pass++;
        total++; if (bus.dp_fn !== 3'd1) $display("FAIL rst_dp_fn got %0d want 1", bus.dp_fn); else pass++;
        total++; if (bus.valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.valid); else pass++;
        total++; if (bus.iot_out !== 128'd0) $display("FAIL rst_iot_out got %h want 0", bus.iot_out); else pass++;
        total++; if (bus.err !== 1'b0) $display("FAIL rst_err got %b want 0", bus.err); else pass++;
        rst = 1'b0;
    endtask

    // Feeds bytes until the model has accepted a full round of 128.
    task automatic collect_round(input bit seq, input bit dense, input int fn_mode);
        logic [127:0] acc, res;
        logic [7:0]   b;
        int           n, cyc, widx;
        bit           en, dd, kp, cpl;
        acc = '0; n = 0; cyc = 0;
        while (n < 128 && cyc < 4000) begin
            en  = dense || ($urandom_range(0, 3) != 0);
            b   = seq ? 8'(n) : 8'($urandom);
            dd  = !dense && ($urandom_range(0, 7) == 0);
            kp  = 1'($urandom);
            res = {$urandom, $urandom, $urandom, $urandom};
            if (fn_mode == 0) cur_fn = 3'($urandom);
            else if (fn_mode == 1) cur_fn = (n < 40) ? 3'd3 : 3'd6;
            else cur_fn = 3'd6;
            bus.in_en = en; bus.iot_in = b; bus.fn_sel = cur_fn;
            bus.dp_done = dd; bus.dp_keep = kp; bus.dp_result = res;
            cpl = 0; widx = n / 16;
            if (en) begin
                acc = {acc[119:0], b};
                if (n == 0) lat_fn = fmap(cur_fn);
                cpl = (n % 16 == 15);
                n++;
            end
            if (dd && kp) exp_out = res;
            @(posedge clk); #1; cyc++;
            total++; if (bus.word_vld !== cpl) $display("FAIL word_vld n=%0d got %b want %b", n, bus.word_vld, cpl); else pass++;
            if (cpl) begin
                total++; if (bus.word !== acc) $display("FAIL word w=%0d got %h want %h", widx, bus.word, acc); else pass++;
                total++; if (bus.dp_first !== (widx == 0)) $display("FAIL dp_first w=%0d got %b", widx, bus.dp_first); else pass++;
                total++; if (bus.dp_last !== (widx == 7)) $display("FAIL dp_last w=%0d got %b", widx, bus.dp_last); else pass++;
            end
            total++; if (bus.busy !== (n == 128)) $display("FAIL collect_busy n=%0d got %b", n, bus.busy); else pass++;
            total++; if (bus.valid !== (dd && kp)) $display("FAIL collect_valid got %b want %b", bus.valid, dd && kp); else pass++;
            total++; if (bus.iot_out !== exp_out) $display("FAIL collect_iot_out got %h want %h", bus.iot_out, exp_out); else pass++;
            total++; if (bus.dp_fn !== fn_exp()) $display("FAIL dp_fn n=%0d got %0d want %0d", n, bus.dp_fn, fn_exp()); else pass++;
            total++; if (bus.err !== exp_err) $display("FAIL collect_err got %b want %b", bus.err, exp_err); else pass++;
        end
        total++; if (n != 128) $display("FAIL collect_bound accepted %0d want 128", n); else pass++;
        bus.in_en = 0; bus.dp_done = 0;
    endtask

    // d = cycle of the wait (1..TMO) carrying dp_done; larger means none.
    task automatic wait_phase(input int d, input bit kp, input logic [127:0] res);
        bit dd, done;
        for (int c = 1; c <= TMO; c++) begin
            dd = (c == d);
            bus.in_en = 1'($urandom); bus.iot_in = 8'h55;
            bus.dp_done = dd; bus.dp_keep = kp; bus.dp_result = res;
            done = dd || (c == TMO);
            if (!dd && c == TMO) exp_err = 1;
            if (dd && kp) exp_out = res;
            @(posedge clk); #1;
            total++; if (bus.busy !== !done) $display("FAIL wait_busy c=%0d got %b want %b", c, bus.busy, !done); else pass++;
            total++; if (bus.valid !== (dd && kp)) $display("FAIL wait_valid c=%0d got %b", c, bus.valid); else pass++;
            total++; if (bus.iot_out !== exp_out) $display("FAIL wait_iot_out got %h want %h", bus.iot_out, exp_out); else pass++;
            total++; if (bus.err !== exp_err) $display("FAIL wait_err c=%0d got %b want %b", c, bus.err, exp_err); else pass++;
            total++; if (bus.word_vld !== 1'b0) $display("FAIL wait_word_vld c=%0d got %b", c, bus.word_vld); else pass++;
            total++; if (bus.dp_fn !== fn_exp()) $display("FAIL wait_dp_fn got %0d want %0d", bus.dp_fn, fn_exp()); else pass++;
            if (done) break;
        end
        bus.dp_done = 0; bus.in_en = 0;
    endtask

    task automatic test_first_round();
        collect_round(1, 1, 0);
        wait_phase(2, 1, {4'hA, {124{1'b1}}});
    endtask

    task automatic test_pass_through();
        logic [127:0] r;
        bus.in_en = 0; bus.dp_done = 1; bus.dp_keep = 0;
        bus.dp_result = {4{$urandom}};
        @(posedge clk); #1;
        total++; if (bus.valid !== 1'b0) $display("FAIL drop_valid got %b want 0", bus.valid); else pass++;
        total++; if (bus.iot_out !== exp_out) $display("FAIL drop_iot_out got %h want %h", bus.iot_out, exp_out); else pass++;
        r = {$urandom, $urandom, $urandom, $urandom};
        bus.dp_keep = 1; bus.dp_result = r; exp_out = r;
        @(posedge clk); #1;
        total++; if (bus.valid !== 1'b1) $display("FAIL keep_valid got %b want 1", bus.valid); else pass++;
        total++; if (bus.iot_out !== exp_out) $display("FAIL keep_iot_out got %h want %h", bus.iot_out, exp_out); else pass++;
        bus.dp_done = 0;
        collect_round(0, 0, 0);
        wait_phase(1, 0, {4{$urandom}});
    endtask

    task automatic test_timeout();
        collect_round(0, 0, 0);
        wait_phase(99, 1, 128'd0);
        collect_round(0, 0, 0);
        wait_phase(4, 1, {4{$urandom}});
    endtask

    task automatic test_expiry_done();
        test_reset();
        collect_round(0, 1, 0);
        wait_phase(TMO, 1, {4{$urandom}});
    endtask

    task automatic test_fn_change();
        collect_round(0, 1, 1);
        wait_phase(3, 1, {4{$urandom}});
        collect_round(0, 0, 2);
        wait_phase(5, 0, 128'd0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            collect_round(0, 1'($urandom), 0);
            wait_phase($urandom_range(1, TMO + 3), 1'($urandom), {4{$urandom}});
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 50; i++) begin
            bus.in_en = 1; bus.iot_in = 8'($urandom);
            @(posedge clk); #1;
        end
        test_reset();
        collect_round(0, 0, 0);
        wait_phase(2, 1, {4{$urandom}});
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_pass_through();
        test_timeout();
        test_expiry_done();
        test_fn_change();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
